// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle MIPS sequencing controller with DM stall and retire counter
module mc_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             ifzero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             npc_sel,
  output logic             jump,
  output logic             jr,
  output logic             jal,
  output logic             regdst,
  output logic             alusrc,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             memwrite,
  output logic [1:0]       extop,
  output logic [3:0]       aluctr,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_ILL, I_ADDU, I_SUBU, I_JR, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_J, I_JAL
  } instr_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_HI   = 2'b10;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  instr_t           ins;
  logic             retire;
  logic [3:0]       alu_ctr_c;
  logic [1:0]       ext_c;
  logic             alusrc_c;

  always_comb begin
    ins = I_ILL;
    case (opcode)
      6'b000000: begin
        case (func)
          6'b100001: ins = I_ADDU;
          6'b100011: ins = I_SUBU;
          6'b001000: ins = I_JR;
          default:   ins = I_ILL;
        endcase
      end
      6'b001101: ins = I_ORI;
      6'b100011: ins = I_LW;
      6'b101011: ins = I_SW;
      6'b000100: ins = I_BEQ;
      6'b001111: ins = I_LUI;
      6'b000010: ins = I_J;
      6'b000011: ins = I_JAL;
      default:   ins = I_ILL;
    endcase
  end

  // ALU/EXT setup is a pure function of the instruction, so MEM and WB hold it for free
  always_comb begin
    alu_ctr_c = ALU_ADD;
    ext_c     = EXT_ZERO;
    alusrc_c  = 1'b0;
    case (ins)
      I_SUBU, I_BEQ: alu_ctr_c = ALU_SUB;
      I_ORI: begin
        alu_ctr_c = ALU_OR;
        alusrc_c  = 1'b1;
      end
      I_LUI: begin
        alu_ctr_c = ALU_OR;
        ext_c     = EXT_HI;
        alusrc_c  = 1'b1;
      end
      I_LW, I_SW: begin
        ext_c    = EXT_SIGN;
        alusrc_c = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = S_FETCH;
    retire   = 1'b0;
    pc_write = 1'b0;
    ir_write = 1'b0;
    npc_sel  = 1'b0;
    jump     = 1'b0;
    jr       = 1'b0;
    jal      = 1'b0;
    regdst   = 1'b0;
    alusrc   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    memwrite = 1'b0;
    extop    = EXT_ZERO;
    aluctr   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        if (ins == I_ILL) retire = 1'b1;
        else              state_d = S_EXEC;
      end
      S_EXEC: begin
        aluctr = alu_ctr_c;
        extop  = ext_c;
        alusrc = alusrc_c;
        case (ins)
          I_ADDU, I_SUBU, I_ORI, I_LUI: state_d = S_WB;
          I_LW, I_SW:                   state_d = S_MEM;
          I_BEQ: begin
            npc_sel  = 1'b1;
            pc_write = ifzero;
            retire   = 1'b1;
          end
          I_J: begin
            jump     = 1'b1;
            pc_write = 1'b1;
            retire   = 1'b1;
          end
          I_JAL: begin
            jump     = 1'b1;
            jal      = 1'b1;
            pc_write = 1'b1;
            regwrite = 1'b1;
            retire   = 1'b1;
          end
          I_JR: begin
            jr       = 1'b1;
            pc_write = 1'b1;
            retire   = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        aluctr = alu_ctr_c;
        extop  = ext_c;
        alusrc = alusrc_c;
        if (!mem_ready) begin
          state_d = S_MEM;
        end else if (ins == I_SW) begin
          memwrite = 1'b1;
          retire   = 1'b1;
        end else if (ins == I_LW) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        aluctr   = alu_ctr_c;
        extop    = ext_c;
        alusrc   = alusrc_c;
        regwrite = 1'b1;
        regdst   = (ins == I_ADDU) || (ins == I_SUBU);
        memtoreg = (ins == I_LW);
        retire   = 1'b1;
      end
      default: ;
    endcase
    // Reset silences FETCH's enables too, so nothing leaks while held
    if (!reset) begin
      retire   = 1'b0;
      pc_write = 1'b0;
      ir_write = 1'b0;
      npc_sel  = 1'b0;
      jump     = 1'b0;
      jr       = 1'b0;
      jal      = 1'b0;
      regdst   = 1'b0;
      alusrc   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      extop    = EXT_ZERO;
      aluctr   = ALU_ADD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign state       = state_q;
  assign instr_done  = retire;
  assign instr_count = count_q;

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - directed bench for mc_control against a per-instruction cycle model
module tb_mc_control;
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, func;
  logic        ifzero, mem_ready;
  logic        pc_write, ir_write, npc_sel, jump, jr, jal, regdst, alusrc;
  logic        memtoreg, regwrite, memwrite, instr_done;
  logic [1:0]  extop;
  logic [3:0]  aluctr;
  logic [2:0]  state;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  mc_control #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .ifzero(ifzero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .npc_sel(npc_sel),
    .jump(jump), .jr(jr), .jal(jal), .regdst(regdst), .alusrc(alusrc), .memtoreg(memtoreg),
    .regwrite(regwrite), .memwrite(memwrite), .extop(extop), .aluctr(aluctr),
    .state(state), .instr_done(instr_done), .instr_count(instr_count)
  );

  typedef struct packed {
    logic pc_write, ir_write, npc_sel, jump, jr, jal, regdst, alusrc, memtoreg, regwrite, memwrite;
    logic [1:0] extop;
    logic [3:0] aluctr;
    logic [2:0] state;
    logic       instr_done;
  } ov_t;

  typedef enum {ADDU, SUBU, JR, ORI, LW, SW, BEQ, LUI, J, JAL, ILL} ins_t;

  ov_t act;
  assign act = {pc_write, ir_write, npc_sel, jump, jr, jal, regdst, alusrc, memtoreg,
                regwrite, memwrite, extop, aluctr, state, instr_done};

  int n_checks = 0;
  int n_pass = 0;
  int model_count = 0;
  int cyc = 0;
  int lat = -1;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, a, e);
  endtask

  function automatic ins_t classify(input logic [5:0] op, input logic [5:0] fn);
    ins_t k;
    k = ILL;
    case (op)
      6'b000000: begin
        if (fn == 6'b100001) k = ADDU;
        else if (fn == 6'b100011) k = SUBU;
        else if (fn == 6'b001000) k = JR;
      end
      6'b001101: k = ORI;
      6'b100011: k = LW;
      6'b101011: k = SW;
      6'b000100: k = BEQ;
      6'b001111: k = LUI;
      6'b000010: k = J;
      6'b000011: k = JAL;
      default:   k = ILL;
    endcase
    return k;
  endfunction

  function automatic ov_t alu_of(input ins_t k);
    ov_t v;
    v = '0;
    case (k)
      SUBU, BEQ: v.aluctr = 4'd1;
      ORI:       begin v.aluctr = 4'd2; v.alusrc = 1'b1; end
      LUI:       begin v.aluctr = 4'd2; v.extop = 2'd2; v.alusrc = 1'b1; end
      LW, SW:    begin v.extop = 2'd1; v.alusrc = 1'b1; end
      default: ;
    endcase
    return v;
  endfunction

  // One cycle: drive mem_ready, compare at the falling edge, advance past the rising edge
  task automatic step(input ov_t e, input logic mr, input string name);
    mem_ready = mr;
    @(negedge clk);
    chk({name, " outputs"}, 32'(act), 32'(e));
    chk({name, " count"}, instr_count, 32'(model_count));
    cyc++;
    if (act.instr_done) lat = cyc;
    @(posedge clk);
    #1;
    if (e.instr_done) model_count++;
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic iz, input int waits, input bit abort_wb, input int exp_lat);
    ins_t k;
    ov_t  e, alu;
    k = classify(op, fn);
    alu = alu_of(k);
    opcode = op;
    func = fn;
    ifzero = iz;
    cyc = 0;
    lat = -1;

    e = '0; e.pc_write = 1'b1; e.ir_write = 1'b1; e.state = 3'd0;
    step(e, 1'($urandom_range(0, 1)), {name, " FETCH"});

    e = '0; e.state = 3'd1; e.instr_done = (k == ILL);
    step(e, 1'($urandom_range(0, 1)), {name, " DECODE"});

    if (k != ILL) begin
      e = alu; e.state = 3'd2;
      case (k)
        BEQ: begin e.npc_sel = 1'b1; e.pc_write = iz; e.instr_done = 1'b1; end
        J:   begin e.jump = 1'b1; e.pc_write = 1'b1; e.instr_done = 1'b1; end
        JAL: begin
          e.jump = 1'b1; e.jal = 1'b1; e.pc_write = 1'b1; e.regwrite = 1'b1; e.instr_done = 1'b1;
        end
        JR:  begin e.jr = 1'b1; e.pc_write = 1'b1; e.instr_done = 1'b1; end
        default: ;
      endcase
      step(e, 1'($urandom_range(0, 1)), {name, " EXEC"});

      if (k == LW || k == SW) begin
        for (int w = 0; w < waits; w++) begin
          e = alu; e.state = 3'd3;
          step(e, 1'b0, {name, " MEM stall"});
        end
        e = alu; e.state = 3'd3;
        if (k == SW) begin e.memwrite = 1'b1; e.instr_done = 1'b1; end
        step(e, 1'b1, {name, " MEM"});
      end

      if (k == ADDU || k == SUBU || k == ORI || k == LUI || k == LW) begin
        if (abort_wb) begin
          reset = 1'b0;
          model_count = 0;
          repeat (3) step('0, 1'b1, {name, " reset in WB"});
          reset = 1'b1;
        end else begin
          e = alu; e.state = 3'd4; e.regwrite = 1'b1;
          e.regdst = (k == ADDU || k == SUBU);
          e.memtoreg = (k == LW);
          e.instr_done = 1'b1;
          step(e, 1'($urandom_range(0, 1)), {name, " WB"});
        end
      end
    end

    if (!abort_wb) chk({name, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    reset = 1'b0;
    opcode = 6'd0;
    func = 6'd0;
    ifzero = 1'b0;
    mem_ready = 1'b0;
    repeat (2) step('0, 1'b1, "power-on reset");
    reset = 1'b1;

    run_instr("addu_abort", 6'b000000, 6'b100001, 1'b0, 0, 1'b1, 0);
    run_instr("addu",       6'b000000, 6'b100001, 1'b0, 0, 1'b0, 4);
    chk("count after addu", instr_count, 32'd1);
    run_instr("subu",       6'b000000, 6'b100011, 1'b1, 0, 1'b0, 4);
    run_instr("ori",        6'b001101, 6'b000000, 1'b0, 0, 1'b0, 4);
    run_instr("lui",        6'b001111, 6'b111111, 1'b0, 0, 1'b0, 4);
    run_instr("lw_stall3",  6'b100011, 6'b000000, 1'b0, 3, 1'b0, 8);
    run_instr("sw_stall2",  6'b101011, 6'b000000, 1'b0, 2, 1'b0, 6);
    run_instr("beq_taken",  6'b000100, 6'b000000, 1'b1, 0, 1'b0, 3);
    run_instr("beq_not",    6'b000100, 6'b000000, 1'b0, 0, 1'b0, 3);
    run_instr("j",          6'b000010, 6'b000000, 1'b0, 0, 1'b0, 3);
    run_instr("jal",        6'b000011, 6'b000000, 1'b0, 0, 1'b0, 3);
    chk("count after jal", instr_count, 32'd10);
    run_instr("illegal_op", 6'b111111, 6'b000000, 1'b0, 0, 1'b0, 2);
    chk("count after jal+illegal", instr_count, 32'd11);
    run_instr("jr",         6'b000000, 6'b001000, 1'b0, 0, 1'b0, 3);
    run_instr("illegal_fn", 6'b000000, 6'b000000, 1'b0, 0, 1'b0, 2);
    run_instr("lw_nostall", 6'b100011, 6'b000000, 1'b1, 0, 1'b0, 5);

    @(negedge clk);
    chk("final count", instr_count, 32'd14);
    chk("final state", 32'(state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle sequencing controller for the MIPS datapath (IFU, GRF, EXT, ALU, DM and the write-back/ALU-source muxes).
- Replaces the single-cycle combinational control. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and asserts per-state write enables and mux selects.
- It stalls on a data-memory ready handshake and counts retired instructions.
- Supported instructions: addu, subu, ori, lw, sw, beq, lui, j, jal, jr.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- opcode  in  6  instr[31:26] from the instruction register (stable from DECODE onward).
- func  in  6  instr[5:0].
- ifzero  in  1  ALU equality flag.
- mem_ready  in  1  DM handshake; 1 = access completes this cycle.
- pc_write  out  1  PC load enable.
- ir_write  out  1  instruction-register load enable.
- npc_sel  out  1  select branch target.
- jump  out  1  select j/jal target.
- jr  out  1  select register target.
- jal  out  1  write-address = 31, write-data = PC+4.
- regdst  out  1  1 = rd, 0 = rt.
- alusrc  out  1  1 = EXT output, 0 = regdata2.
- memtoreg  out  1  write-data from DM.
- regwrite  out  1  GRF write enable.
- memwrite  out  1  DM write enable.
- extop  out  2  00 zero-ext, 01 sign-ext, 10 imm<<16.
- aluctr  out  4  0000 ADD, 0001 SUB, 0010 OR.
- state  out  3  current state, for debug.
- instr_done  out  1  one-cycle pulse on retire.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Decode:
  - R-type: opcode 000000 with func addu 100001, subu 100011, jr 001000.
  - I/J-type opcodes: ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011.
  - Any other opcode/func is illegal and is treated as a NOP.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Encodings 5–7 go to FETCH on the next edge with all enables 0.
- FETCH:
  - ir_write=1, pc_write=1, npc_sel=jump=jr=0 (PC <= PC+4).
  - Always -> DECODE.
- DECODE:
  - No enables asserted.
  - Illegal -> FETCH, retire, no architectural change.
  - All others -> EXEC.
- EXEC:
  - addu/subu: aluctr ADD/SUB, alusrc=0 -> WB.
  - ori: OR, extop=00, alusrc=1 -> WB.
  - lui: OR, extop=10, alusrc=1 -> WB.
  - lw/sw: ADD, extop=01, alusrc=1 -> MEM.
  - beq: SUB, alusrc=0, npc_sel=1, pc_write=ifzero -> FETCH, retire.
  - j: jump=1, pc_write=1 -> FETCH, retire.
  - jal: jump=1, jal=1, pc_write=1, regwrite=1 -> FETCH, retire. The written value is the already-incremented PC+4.
  - jr: jr=1, pc_write=1 -> FETCH, retire.
- MEM:
  - ALU controls held as in EXEC.
  - sw: memwrite = mem_ready. When mem_ready=1 -> FETCH, retire.
  - lw: when mem_ready=1 -> WB.
  - While mem_ready=0: stay in MEM, all enables 0.
- WB:
  - regwrite=1, ALU controls held as in EXEC.
  - R-type: regdst=1, memtoreg=0.
  - ori/lui: regdst=0, memtoreg=0.
  - lw: regdst=0, memtoreg=1.
  - -> FETCH, retire.
- Retire:
  - instr_done=1 in the retiring cycle.
  - instr_count increments by 1 at that edge and wraps from all-ones to 0.
- Latency in cycles, assuming mem_ready is always 1:
  - illegal 2; beq/j/jal/jr 3; R-type/ori/lui/sw 4; lw 5.
  - Each cycle of mem_ready=0 adds one cycle.
- Outputs not listed for a state are 0. extop defaults to 00 and aluctr to ADD.
- Reset:
  - While reset=0: state=FETCH, instr_count=0, and every output (including pc_write and ir_write) is forced to 0 regardless of state.
  - Reset asserted mid-instruction abandons it immediately: no pending regwrite or memwrite.
  - After reset deasserts, the first edge performs the FETCH.
- mem_ready is ignored outside MEM.
- opcode/func are sampled only in DECODE, EXEC, MEM and WB; their value during FETCH is don't-care.

Test Plan:
1. reset=0 for 3 cycles while in WB of an addu -> all enables 0, state=0, instr_count=0; after release, cycle 1 shows ir_write=1 and pc_write=1.
2. addu (func 100001), mem_ready=1 -> states 0,1,2,4; in WB regwrite=1, regdst=1, aluctr=0000; instr_done pulses once; instr_count=1.
3. lw with mem_ready held 0 for 3 MEM cycles -> 8 cycles total; regwrite=1 only in WB with memtoreg=1, extop=01.
4. sw with mem_ready=0,0,1 -> memwrite high only in the mem_ready=1 cycle; no regwrite; next state FETCH.
5. beq with ifzero=1 and then ifzero=0 -> 3 cycles each; pc_write=1/0 respectively in EXEC with npc_sel=1.
6. jal, then an illegal opcode 111111 -> jal: EXEC asserts jump, jal, regwrite and pc_write; illegal: 2 cycles with no enables after FETCH; instr_count advances by 2.
